// File: rtl/slow_clk_gen.sv
// Cascaded slow-clock divider: clk_s = clk/d_s, clk_ss = clk_s/d_ss, with rising-edge tick strobes.
// Define SLOW_CLK_CFG_EN to make both divisors run-time configurable through the cfg handshake.
module slow_clk_gen #(
    parameter int DIV_S  = 50000,
    parameter int DIV_SS = 100,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
`ifdef SLOW_CLK_CFG_EN
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div_s,
    input  logic [CNT_W-1:0] cfg_div_ss,
`endif
    output logic             clk_s,
    output logic             clk_ss,
    output logic             tick_s,
    output logic             tick_ss
);

    localparam logic [CNT_W-1:0] DIV_S_W  = CNT_W'(DIV_S);
    localparam logic [CNT_W-1:0] DIV_SS_W = CNT_W'(DIV_SS);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

    logic [CNT_W-1:0] d_s, d_ss, h_s, h_ss;
    logic [CNT_W-1:0] cnt_s_q, cnt_s_d, cnt_ss_q, cnt_ss_d;
    logic             clk_s_q, clk_s_d, clk_ss_q, clk_ss_d;
    logic             tick_s_q, tick_s_d, tick_ss_q, tick_ss_d;
    logic             s_wrap, ss_wrap;

    assign h_s     = d_s >> 1;
    assign h_ss    = d_ss >> 1;
    assign s_wrap  = en && (cnt_s_q == d_s - ONE);
    assign ss_wrap = s_wrap && (cnt_ss_q == d_ss - ONE);

    always_comb begin
        cnt_s_d   = cnt_s_q;
        cnt_ss_d  = cnt_ss_q;
        clk_s_d   = clk_s_q;
        clk_ss_d  = clk_ss_q;
        tick_s_d  = 1'b0;
        tick_ss_d = 1'b0;
        if (en) begin
            if (s_wrap) begin
                cnt_s_d  = '0;
                clk_s_d  = 1'b1;
                tick_s_d = 1'b1;
            end else begin
                if (cnt_s_q == h_s - ONE) begin
                    clk_s_d = 1'b0;
                end
                cnt_s_d = cnt_s_q + ONE;
            end
            // The ss stage advances once per clk_s period, on the s-wrap edge.
            if (s_wrap) begin
                if (ss_wrap) begin
                    cnt_ss_d  = '0;
                    clk_ss_d  = 1'b1;
                    tick_ss_d = 1'b1;
                end else begin
                    if (cnt_ss_q == h_ss - ONE) begin
                        clk_ss_d = 1'b0;
                    end
                    cnt_ss_d = cnt_ss_q + ONE;
                end
            end
        end
    end

`ifdef SLOW_CLK_CFG_EN
    logic [CNT_W-1:0] d_s_q, d_s_d, d_ss_q, d_ss_d;
    logic [CNT_W-1:0] pend_s_q, pend_s_d, pend_ss_q, pend_ss_d;
    logic             pending_q, pending_d;

    function automatic logic [CNT_W-1:0] sanitise(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        r = v & ~ONE;
        if (r < TWO) begin
            r = TWO;
        end
        return r;
    endfunction

    // New divisors only take effect on an ss-wrap so no period is ever cut short or stretched.
    always_comb begin
        d_s_d     = d_s_q;
        d_ss_d    = d_ss_q;
        pend_s_d  = pend_s_q;
        pend_ss_d = pend_ss_q;
        pending_d = pending_q;
        if (pending_q && ss_wrap) begin
            d_s_d     = pend_s_q;
            d_ss_d    = pend_ss_q;
            pending_d = 1'b0;
        end else if (!pending_q && cfg_valid) begin
            pend_s_d  = sanitise(cfg_div_s);
            pend_ss_d = sanitise(cfg_div_ss);
            pending_d = 1'b1;
        end
    end

    assign d_s       = d_s_q;
    assign d_ss      = d_ss_q;
    assign cfg_ready = ~pending_q;
`else
    assign d_s  = DIV_S_W;
    assign d_ss = DIV_SS_W;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_s_q   <= '0;
            cnt_ss_q  <= '0;
            clk_s_q   <= 1'b0;
            clk_ss_q  <= 1'b0;
            tick_s_q  <= 1'b0;
            tick_ss_q <= 1'b0;
`ifdef SLOW_CLK_CFG_EN
            d_s_q     <= DIV_S_W;
            d_ss_q    <= DIV_SS_W;
            pend_s_q  <= DIV_S_W;
            pend_ss_q <= DIV_SS_W;
            pending_q <= 1'b0;
`endif
        end else begin
            cnt_s_q   <= cnt_s_d;
            cnt_ss_q  <= cnt_ss_d;
            clk_s_q   <= clk_s_d;
            clk_ss_q  <= clk_ss_d;
            tick_s_q  <= tick_s_d;
            tick_ss_q <= tick_ss_d;
`ifdef SLOW_CLK_CFG_EN
            d_s_q     <= d_s_d;
            d_ss_q    <= d_ss_d;
            pend_s_q  <= pend_s_d;
            pend_ss_q <= pend_ss_d;
            pending_q <= pending_d;
`endif
        end
    end

    assign clk_s   = clk_s_q;
    assign clk_ss  = clk_ss_q;
    assign tick_s  = tick_s_q;
    assign tick_ss = tick_ss_q;

endmodule
